// File: rtl/lap_stopwatch.sv
// Multi-digit BCD stopwatch with start/stop/resume, lap capture and a sticky
// overflow flag. Two raw active-low buttons in, multiplexed common-cathode
// 7-segment display out.
//
// state      | meaning
// -----------+-----------------------------------------------
// S_IDLE     | cleared, counter halted, showing count
// S_RUN      | counter advancing, showing count
// S_LAP_VIEW | counter advancing, showing frozen lap value
// S_STOP_LAP | counter halted, showing frozen lap value
// S_STOP     | counter halted, showing count
module lap_stopwatch #(
    parameter int                    NUM_DIGITS   = 6,
    parameter int                    INC_CE_DIV   = 10_000_000,
    parameter int                    SEL_CE_DIV   = 100_000,
    parameter int                    DBNC_DIV     = 500_000,
    parameter int                    SEG_CLK_BITS = 8,
    parameter logic [NUM_DIGITS-1:0] DP_MASK      = 6'b001010
) (
    input  logic                  SYSCLK,
    input  logic                  RESETN,
    input  logic                  BTN_SS,
    input  logic                  BTN_LAP,
    output logic                  SEGA,
    output logic                  SEGB,
    output logic                  SEGC,
    output logic                  SEGD,
    output logic                  SEGE,
    output logic                  SEGF,
    output logic                  SEGG,
    output logic                  SEGDP,
    output logic [NUM_DIGITS-1:0] SEGCAT,
    output logic                  SEGCLK,
    output logic                  RUNNING,
    output logic                  LAP_SHOWN,
    output logic                  OVF
);

    localparam int CW   = 4 * NUM_DIGITS;
    localparam int DB_W = $clog2(DBNC_DIV);
    localparam int PS_W = $clog2(INC_CE_DIV);
    localparam int ST_W = $clog2(SEL_CE_DIV);
    localparam int SL_W = $clog2(NUM_DIGITS);

    localparam logic [DB_W-1:0] DB_RELOAD = DB_W'(DBNC_DIV - 1);
    localparam logic [PS_W-1:0] PS_LAST   = PS_W'(INC_CE_DIV - 1);
    localparam logic [ST_W-1:0] ST_RELOAD = ST_W'(SEL_CE_DIV - 1);
    localparam logic [SL_W-1:0] SEL_LAST  = SL_W'(NUM_DIGITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_LAP_VIEW, S_STOP_LAP, S_STOP
    } state_t;

    // bit 0 = start/stop, bit 1 = lap; 1 = released
    logic [1:0]            sync1, sync2, db_lvl;
    logic [1:0][DB_W-1:0]  db_tmr;
    logic                  ss_evt, lap_evt;

    state_t                state;
    logic [PS_W-1:0]       presc;
    logic [CW-1:0]         count, lap, count_inc, disp;
    logic                  count_wrap, counting, inc;

    logic [ST_W-1:0]       sel_tmr;
    logic [SL_W-1:0]       sel;
    logic [SEG_CLK_BITS-1:0] seg_div;
    logic [3:0]            digit;
    logic [6:0]            seg;

    // Two-flop synchronisers for the raw asynchronous buttons.
    always_ff @(posedge SYSCLK or negedge RESETN) begin
        if (!RESETN) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= {BTN_LAP, BTN_SS};
            sync2 <= sync1;
        end
    end

    // Debounce: down-counter reloads whenever the synchronised level matches the
    // accepted level, so only an unbroken run of DBNC_DIV differing samples is accepted.
    always_ff @(posedge SYSCLK or negedge RESETN) begin
        if (!RESETN) begin
            db_lvl <= 2'b11;
            db_tmr <= {2{DB_RELOAD}};
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db_lvl[i]) begin
                    db_tmr[i] <= DB_RELOAD;
                end else if (db_tmr[i] == '0) begin
                    db_lvl[i] <= sync2[i];
                    db_tmr[i] <= DB_RELOAD;
                end else begin
                    db_tmr[i] <= db_tmr[i] - 1'b1;
                end
            end
        end
    end

    assign ss_evt  = db_lvl[0] & ~sync2[0] & (db_tmr[0] == '0);
    assign lap_evt = db_lvl[1] & ~sync2[1] & (db_tmr[1] == '0);

    // BCD ripple increment of the count; carry out of the top digit flags a wrap.
    always_comb begin
        logic carry;
        carry     = 1'b1;
        count_inc = count;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (count[4*i +: 4] >= 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        count_wrap = carry;
    end

    assign counting = (state == S_RUN) || (state == S_LAP_VIEW);
    assign inc      = counting && (presc == PS_LAST);

    // Control FSM with prescaler, count, lap register and registered status outputs.
    // Captures use the pre-increment count; start/stop wins over lap in the same cycle.
    always_ff @(posedge SYSCLK or negedge RESETN) begin
        if (!RESETN) begin
            state     <= S_IDLE;
            presc     <= '0;
            count     <= '0;
            lap       <= '0;
            OVF       <= 1'b0;
            RUNNING   <= 1'b0;
            LAP_SHOWN <= 1'b0;
        end else begin
            if (counting) begin
                presc <= inc ? '0 : presc + 1'b1;
                if (inc) begin
                    count <= count_inc;
                    if (count_wrap) OVF <= 1'b1;
                end
            end
            case (state)
                S_IDLE: begin
                    if (ss_evt) begin
                        state   <= S_RUN;
                        presc   <= '0;
                        RUNNING <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (ss_evt) begin
                        state   <= S_STOP;
                        RUNNING <= 1'b0;
                    end else if (lap_evt) begin
                        state     <= S_LAP_VIEW;
                        lap       <= count;
                        LAP_SHOWN <= 1'b1;
                    end
                end
                S_LAP_VIEW: begin
                    if (ss_evt) begin
                        state   <= S_STOP_LAP;
                        RUNNING <= 1'b0;
                    end else if (lap_evt) begin
                        lap <= count;
                    end
                end
                S_STOP_LAP: begin
                    if (ss_evt) begin
                        state   <= S_LAP_VIEW;
                        RUNNING <= 1'b1;
                    end else if (lap_evt) begin
                        state     <= S_STOP;
                        LAP_SHOWN <= 1'b0;
                    end
                end
                S_STOP: begin
                    if (ss_evt) begin
                        state   <= S_RUN;
                        RUNNING <= 1'b1;
                    end else if (lap_evt) begin
                        state <= S_IDLE;
                        count <= '0;
                        lap   <= '0;
                        OVF   <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    RUNNING   <= 1'b0;
                    LAP_SHOWN <= 1'b0;
                end
            endcase
        end
    end

    // Digit multiplexer and free-running segment-driver clock divider.
    always_ff @(posedge SYSCLK or negedge RESETN) begin
        if (!RESETN) begin
            sel_tmr <= ST_RELOAD;
            sel     <= '0;
            seg_div <= '0;
        end else begin
            seg_div <= seg_div + 1'b1;
            if (sel_tmr == '0) begin
                sel_tmr <= ST_RELOAD;
                sel     <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
            end else begin
                sel_tmr <= sel_tmr - 1'b1;
            end
        end
    end

    assign disp   = LAP_SHOWN ? lap : count;
    assign digit  = disp[4*sel +: 4];
    assign SEGCAT = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << sel;
    assign SEGDP  = DP_MASK[sel];
    assign SEGCLK = seg_div[SEG_CLK_BITS-1];

    // 7-segment decode, bit order {a,b,c,d,e,f,g}; non-decimal codes blank the digit.
    always_comb begin
        case (digit)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
    end

    assign {SEGA, SEGB, SEGC, SEGD, SEGE, SEGF, SEGG} = seg;

endmodule
